// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular arbiter that shares one 8-bit UART transmitter
// between NUM_REQ byte-stream requesters and sequences each byte through en/busy.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 tx_en,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic                 timeout_pulse,
    output logic                 active
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int TMR_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [IDX_W:0]   NUM_REQ_W = (IDX_W + 1)'(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_W = TMR_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOCKED,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DONE
    } state_t;

    state_t             state, state_n;
    logic [IDX_W-1:0]   owner, owner_n;
    logic [IDX_W-1:0]   rr_ptr, rr_ptr_n;
    logic [TMR_W-1:0]   timer, timer_n;
    logic [NUM_REQ-1:0] grant_n;
    logic [7:0]         tx_data_n;
    logic               last_r, last_n;
    logic               timeout_n;

    logic               found;
    logic [IDX_W-1:0]   winner;
    logic [IDX_W:0]     cand;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == LAST_IDX) ? '0 : i + IDX_W'(1);
    endfunction

    // Wrapping priority search starting at rr_ptr.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
            if (cand >= NUM_REQ_W) cand = cand - NUM_REQ_W;
            if (!found && req_valid[cand[IDX_W-1:0]]) begin
                found  = 1'b1;
                winner = cand[IDX_W-1:0];
            end
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_n   = state;
        owner_n   = owner;
        grant_n   = grant;
        rr_ptr_n  = rr_ptr;
        timer_n   = timer;
        tx_data_n = tx_data;
        last_n    = last_r;
        timeout_n = 1'b0;
        req_ready = '0;
        tx_en     = 1'b0;

        case (state)
            S_IDLE: begin
                if (found) begin
                    state_n          = S_LOCKED;
                    owner_n          = winner;
                    grant_n          = '0;
                    grant_n[winner]  = 1'b1;
                    timer_n          = '0;
                end
            end
            S_LOCKED: begin
                if (req_valid[owner]) begin
                    // Gated by reset so no requester sees a handshake the reset will discard.
                    req_ready[owner] = !reset;
                    tx_data_n        = req_data[{owner, 3'b000} +: 8];
                    last_n           = req_last[owner];
                    timer_n          = '0;
                    state_n          = S_ISSUE;
                end else if (TIMEOUT_CYCLES != 0) begin
                    if (timer == TIMEOUT_W - TMR_W'(1)) begin
                        timeout_n = 1'b1;
                        grant_n   = '0;
                        rr_ptr_n  = next_idx(owner);
                        timer_n   = '0;
                        state_n   = S_IDLE;
                    end else begin
                        timer_n = timer + TMR_W'(1);
                    end
                end
            end
            S_ISSUE: begin
                tx_en   = !reset;
                state_n = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (tx_busy) state_n = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    if (last_r) begin
                        grant_n  = '0;
                        rr_ptr_n = next_idx(owner);
                        state_n  = S_IDLE;
                    end else begin
                        timer_n = '0;
                        state_n = S_LOCKED;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            owner         <= '0;
            rr_ptr        <= '0;
            timer         <= '0;
            grant         <= '0;
            tx_data       <= '0;
            last_r        <= 1'b0;
            timeout_pulse <= 1'b0;
        end else begin
            state         <= state_n;
            owner         <= owner_n;
            rr_ptr        <= rr_ptr_n;
            timer         <= timer_n;
            grant         <= grant_n;
            tx_data       <= tx_data_n;
            last_r        <= last_n;
            timeout_pulse <= timeout_n;
        end
    end

    assign active = (state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized self-checking bench for uart_tx_arbiter: requester queues, a model
// transmitter, and a message-level arbitration model derived from the grant rules.
module tb_uart_tx_arbiter;

    localparam int N = 4;
    localparam int T = 20;

    logic           clk;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   grant;
    logic           tx_en;
    logic [7:0]     tx_data;
    logic           tx_busy;
    logic           timeout_pulse;
    logic           active;

    uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(T)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .grant        (grant),
        .tx_en        (tx_en),
        .tx_data      (tx_data),
        .tx_busy      (tx_busy),
        .timeout_pulse(timeout_pulse),
        .active       (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Requester byte queues: {last, data}.
    logic [8:0] q [N][$];
    logic [7:0] sb [$];
    logic [7:0] decoded [$];
    int         grant_log [$];

    // Model transmitter.
    bit         start_pending;
    int         busy_left;
    logic [7:0] uart_byte;

    // Arbitration model.
    int   exp_owner;
    int   exp_rr;
    bit   locked;
    int   idle_cnt;
    bit   cur_last;
    bit   exp_tx_en;
    bit   exp_to;
    logic [N-1:0] prev_grant;

    int ready_cnt, tx_en_cnt, to_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    function automatic bit idle_now();
        bit e;
        e = 1'b1;
        for (int i = 0; i < N; i++) if (q[i].size() != 0) e = 1'b0;
        return e && exp_owner < 0 && !tx_busy && !start_pending;
    endfunction

    task automatic model_init();
        exp_owner  = -1;
        exp_rr     = 0;
        locked     = 0;
        idle_cnt   = 0;
        cur_last   = 0;
        exp_tx_en  = 0;
        exp_to     = 0;
        prev_grant = '0;
        start_pending = 0;
        busy_left  = 0;
    endtask

    // Asserted in the current cycle; outputs checked after the reset edge.
    task automatic do_reset();
        reset     = 1'b1;
        tx_busy   = 1'b0;
        req_valid = '0;
        for (int i = 0; i < N; i++) q[i].delete();
        sb.delete();
        model_init();
        @(negedge clk);
        #1;
        check("rst_grant", grant, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_tx_en", tx_en, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_timeout", timeout_pulse, 0);
        check("rst_active", active, 0);
        reset = 1'b0;
    endtask

    // One clock cycle: drive at negedge, sample 1 ns later, then advance the model.
    task automatic step(input bit allow_stall);
        logic [N-1:0] v;
        bit busy_fell;
        bit picked;
        int idx;
        bit tx_en_n, to_n;
        @(negedge clk);
        busy_fell = 0;
        if (start_pending) begin
            tx_busy       = 1'b1;
            busy_left     = $urandom_range(2, 6);
            start_pending = 0;
        end else if (tx_busy) begin
            busy_left--;
            if (busy_left == 0) begin
                tx_busy   = 1'b0;
                busy_fell = 1;
                decoded.push_back(uart_byte);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (q[i].size() > 0 && !(allow_stall && $urandom_range(0, 7) == 0)) begin
                v[i]              = 1'b1;
                req_data[8*i +: 8] = q[i][0][7:0];
                req_last[i]       = q[i][0][8];
            end else begin
                v[i]              = 1'b0;
                req_data[8*i +: 8] = 8'($urandom);
                req_last[i]       = 1'($urandom);
            end
        end
        req_valid = v;
        #1;

        check("grant", grant, (exp_owner < 0) ? '0 : onehot(exp_owner));
        check("active", active, (exp_owner >= 0) ? 1 : 0);
        check("req_ready", req_ready,
              (exp_owner >= 0 && locked && v[exp_owner]) ? onehot(exp_owner) : '0);
        check("tx_en", tx_en, exp_tx_en);
        check("timeout_pulse", timeout_pulse, exp_to);
        if (tx_busy) check("tx_data_hold", tx_data, uart_byte);
        if (busy_fell) begin
            if (sb.size() == 0) check("decode_extra", 1, 0);
            else                check("decode_byte", uart_byte, sb.pop_front());
        end

        if (|req_ready) ready_cnt++;
        if (timeout_pulse) to_cnt++;
        if (tx_en) begin
            tx_en_cnt++;
            start_pending = 1;
            uart_byte     = tx_data;
        end
        if (grant != '0 && prev_grant == '0)
            for (int i = 0; i < N; i++) if (grant[i]) grant_log.push_back(i);
        prev_grant = grant;

        tx_en_n = 0;
        to_n    = 0;
        picked  = 0;
        if (exp_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                idx = (exp_rr + k) % N;
                if (!picked && v[idx]) begin
                    picked    = 1;
                    exp_owner = idx;
                    locked    = 1;
                    idle_cnt  = 0;
                end
            end
        end else if (locked) begin
            if (v[exp_owner]) begin
                sb.push_back(q[exp_owner][0][7:0]);
                cur_last = q[exp_owner][0][8];
                void'(q[exp_owner].pop_front());
                locked   = 0;
                idle_cnt = 0;
                tx_en_n  = 1;
            end else begin
                idle_cnt++;
                if (idle_cnt == T) begin
                    exp_rr    = (exp_owner + 1) % N;
                    exp_owner = -1;
                    locked    = 0;
                    to_n      = 1;
                end
            end
        end else if (busy_fell) begin
            if (cur_last) begin
                exp_rr    = (exp_owner + 1) % N;
                exp_owner = -1;
            end else begin
                locked   = 1;
                idle_cnt = 0;
            end
        end
        exp_tx_en = tx_en_n;
        exp_to    = to_n;
    endtask

    task automatic run_until_idle(input int budget, input bit allow_stall, input string tag);
        int n;
        n = 0;
        do begin
            step(allow_stall);
            n++;
        end while (!idle_now() && n < budget);
        check({tag, "_drained"}, idle_now(), 1);
    endtask

    task automatic clear_stats();
        decoded.delete();
        grant_log.delete();
        ready_cnt = 0;
        tx_en_cnt = 0;
        to_cnt    = 0;
    endtask

    initial begin
        int rr_exp[5];
        int bytes, len, r;
        int n;
        rr_exp    = '{0, 1, 2, 3, 0};
        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_busy   = 1'b0;
        clear_stats();
        do_reset();

        // Single byte from requester 0.
        clear_stats();
        q[0].push_back({1'b1, 8'h41});
        run_until_idle(100, 0, "single");
        check("single_count", decoded.size(), 1);
        if (decoded.size() > 0) check("single_byte", decoded[0], 8'h41);
        check("single_ready_cnt", ready_cnt, 1);
        check("single_tx_en_cnt", tx_en_cnt, 1);

        // Round robin, two-byte messages, requester 0 has a second message.
        do_reset();
        clear_stats();
        for (int i = 0; i < N; i++) begin
            q[i].push_back({1'b0, 8'(8'h10 + i)});
            q[i].push_back({1'b1, 8'(8'h20 + i)});
        end
        q[0].push_back({1'b0, 8'h30});
        q[0].push_back({1'b1, 8'h31});
        run_until_idle(500, 0, "rr");
        check("rr_grants", grant_log.size(), 5);
        for (int i = 0; i < 5 && i < grant_log.size(); i++) check("rr_order", grant_log[i], rr_exp[i]);
        check("rr_bytes", decoded.size(), 10);

        // Lock: requester 0 waits while 2 finishes its message.
        clear_stats();
        q[2].push_back({1'b0, 8'hB0});
        q[2].push_back({1'b1, 8'hB1});
        n = 0;
        do begin step(0); n++; end while (grant != 4'b0100 && n < 20);
        check("lock_grant2", grant, 4'b0100);
        q[0].push_back({1'b1, 8'hA5});
        run_until_idle(200, 0, "lock");
        check("lock_grants", grant_log.size(), 2);
        if (grant_log.size() == 2) check("lock_next", grant_log[1], 0);

        // Timeout: requester 1 sends a non-last byte then goes silent.
        clear_stats();
        q[1].push_back({1'b0, 8'h55});
        n = 0;
        do begin step(0); n++; end while (q[1].size() != 0 && n < 20);
        check("to_handshake", q[1].size(), 0);
        q[0].push_back({1'b1, 8'hA0});
        q[2].push_back({1'b1, 8'hC2});
        run_until_idle(300, 0, "timeout");
        check("to_pulses", to_cnt, 1);
        check("to_grants", grant_log.size(), 3);
        if (grant_log.size() >= 2) check("to_next_search", grant_log[1], 2);

        // Reset during WAIT_DONE, then a fresh request.
        clear_stats();
        q[3].push_back({1'b1, 8'h7E});
        n = 0;
        do begin step(0); n++; end while (!tx_busy && n < 20);
        check("mid_busy", tx_busy, 1);
        step(0);
        do_reset();
        clear_stats();
        q[3].push_back({1'b1, 8'h3C});
        run_until_idle(100, 0, "post_reset");
        check("post_reset_cnt", decoded.size(), 1);
        if (decoded.size() > 0) check("post_reset_byte", decoded[0], 8'h3C);

        // Randomized 100-byte run with owner stalls.
        clear_stats();
        bytes = 0;
        while (bytes < 100) begin
            r   = $urandom_range(0, N - 1);
            len = $urandom_range(1, 4);
            if (len > 100 - bytes) len = 100 - bytes;
            for (int j = 0; j < len; j++) q[r].push_back({(j == len - 1), 8'($urandom)});
            bytes += len;
        end
        run_until_idle(20000, 1, "random");
        check("rand_decoded", decoded.size(), 100);
        check("rand_ready_vs_en", ready_cnt, tx_en_cnt);
        check("rand_en_vs_decoded", tx_en_cnt, decoded.size());

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one 8-bit UART transmitter between NUM_REQ byte-stream requesters (e.g. game logic, debug, score reporter).
- Arbitration is round-robin at message granularity: a grant holds until the requester sends a byte flagged last, or until it goes silent for TIMEOUT_CYCLES.
- Sits between requesters and the transmitter's en/data/busy interface and sequences each byte: issue, wait for busy to rise, wait for busy to fall.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 1_000_000, idle cycles in LOCKED before a grant is revoked; 0 disables the timeout.

Ports:
- clk  input  1  system clock (100 MHz).
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  requester i has a byte available.
- req_data  input  8*NUM_REQ  byte of requester i at bits [8i+7:8i].
- req_last  input  NUM_REQ  byte of requester i ends its message.
- req_ready  output  NUM_REQ  byte accepted from requester i this cycle.
- grant  output  NUM_REQ  one-hot, registered; current owner of the transmitter.
- tx_en  output  1  to transmitter enable; single-cycle pulse.
- tx_data  output  8  to transmitter data; stable from the tx_en cycle until busy falls.
- tx_busy  input  1  transmitter busy. Rises the cycle after tx_en and stays high for the whole frame.
- timeout_pulse  output  1  one-cycle pulse when a grant is revoked by timeout.
- active  output  1  high whenever state is not IDLE.

Behaviour:
- Reset values (next clk edge with reset=1, overrides everything, including mid-frame):
  - All outputs 0: grant, req_ready, tx_en, tx_data, timeout_pulse, active.
  - State IDLE, rr_ptr=0, idle timer 0.
- States: IDLE, LOCKED, ISSUE, WAIT_ACK, WAIT_DONE.
- IDLE:
  - Search req_valid starting at index rr_ptr, wrapping modulo NUM_REQ; the first set bit wins.
  - Next cycle: grant=onehot(winner), state LOCKED, timer cleared. Arbitration latency is 1 cycle.
  - No req_valid set: stay in IDLE.
- LOCKED (owner g):
  - If req_valid[g]: req_ready[g]=1 combinationally this cycle. Capture req_data[g] into tx_data and req_last[g] into last_r. Next state ISSUE.
  - req_ready is only ever asserted for the owner, and only in LOCKED with req_valid[g] high.
  - Timer: increments each cycle with req_valid[g]=0 and clears on a handshake. When it reaches TIMEOUT_CYCLES (nonzero): timeout_pulse=1 for one cycle, grant=0, rr_ptr=(g+1) mod NUM_REQ, next state IDLE.
  - Timer width is clog2(TIMEOUT_CYCLES+1).
- ISSUE: tx_en=1 for exactly one cycle. Next state WAIT_ACK.
- WAIT_ACK: hold until tx_busy=1, then WAIT_DONE. There is no timeout here.
- WAIT_DONE:
  - Hold until tx_busy=0.
  - If last_r=1: grant=0, rr_ptr=(g+1) mod NUM_REQ, next state IDLE.
  - Otherwise next state LOCKED, timer cleared.
- Non-owner req_valid is ignored while a grant is held. Non-owners see req_ready=0 and may hold their data indefinitely.
- Back-to-back message bytes: at least 1 cycle of gap after busy falls (WAIT_DONE to LOCKED to ISSUE). The UART line gains at most ~3 cycles of idle between frames.
- Owner drops req_valid mid-message: no byte is issued, grant is held, the timer runs.
- Single requester: re-arbitration after its message regrants the same requester after 1 IDLE cycle.
- The transmitter must be held in reset by the same reset signal (inverted at its active-low input). A reset mid-frame therefore leaves no stale busy.

Test Plan:
- Single byte: NUM_REQ=4, req_valid=0001, data 0x41, last=1. Expect grant=0001 1 cycle later, one req_ready pulse, one tx_en pulse with tx_data=0x41, then IDLE after busy falls. A model UART decodes 0x41.
- Round-robin: all four valid, each sending 2-byte messages. Expect grants in order 0,1,2,3,0 and the bytes of each message contiguous on the line, never interleaved.
- Lock: req 2 owns mid-message while req 0 asserts valid. req_ready[0] stays 0 until req 2's last byte has completed, then grant=0001... following rr_ptr=3: grant goes to req 3 if valid, else req 0.
- Timeout: TIMEOUT_CYCLES=20, req 1 sends one non-last byte then drops valid. Exactly 20 cycles after the first idle LOCKED cycle: timeout_pulse=1, grant=0, and the next grant search starts at req 2.
- Reset mid-frame: assert reset during WAIT_DONE. Next cycle all outputs 0 and state IDLE. A new request after release is granted and completes normally.
- tx_en integrity: across a 100-byte randomized run, tx_en is never high while tx_busy=1 or outside ISSUE. Count of req_ready pulses equals count of tx_en pulses equals bytes decoded.
